// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the execute-register layout used by the execute stage.
package y86_pkg;

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRrmovq = 4'h2;
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;

    localparam logic [2:0] SAok = 3'd1;
    localparam logic [2:0] SHlt = 3'd2;
    localparam logic [2:0] SAdr = 3'd3;
    localparam logic [2:0] SIns = 3'd4;

    localparam logic [3:0] AluAdd = 4'h0;
    localparam logic [3:0] AluSub = 4'h1;
    localparam logic [3:0] AluAnd = 4'h2;
    localparam logic [3:0] AluXor = 4'h3;

    localparam logic [3:0] CondYes = 4'h0;
    localparam logic [3:0] CondLe  = 4'h1;
    localparam logic [3:0] CondL   = 4'h2;
    localparam logic [3:0] CondE   = 4'h3;
    localparam logic [3:0] CondNe  = 4'h4;
    localparam logic [3:0] CondGe  = 4'h5;
    localparam logic [3:0] CondG   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    // Condition codes are ordered {ZF, SF, OF}.
    localparam logic [2:0] CcReset = 3'b100;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } e_reg_t;

    localparam e_reg_t EBubble = '{
        stat:  SAok,
        icode: INop,
        ifun:  4'h0,
        valc:  64'h0,
        vala:  64'h0,
        valb:  64'h0,
        dste:  RNONE,
        dstm:  RNONE,
        srca:  RNONE,
        srcb:  RNONE
    };

    function automatic logic stat_blocks_cc(input logic [2:0] stat);
        return (stat == SAdr) || (stat == SIns) || (stat == SHlt);
    endfunction

    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of, lt, res;
        {zf, sf, of} = cc;
        lt = sf ^ of;
        case (ifun)
            CondYes: res = 1'b1;
            CondLe:  res = lt | zf;
            CondL:   res = lt;
            CondE:   res = zf;
            CondNe:  res = ~zf;
            CondGe:  res = ~lt;
            CondG:   res = ~lt & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU: computes B op A and the ZF/SF/OF flags for that result.
module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [3:0]  i_fun,
    output logic [63:0] o_r,
    output logic        o_zf,
    output logic        o_sf,
    output logic        o_of
);

    logic [63:0] w_sum;
    logic [63:0] w_diff;

    assign w_sum  = i_b + i_a;
    assign w_diff = i_b - i_a;

    always_comb begin
        o_r  = 64'h0;
        o_of = 1'b0;
        case (i_fun)
            AluAdd: begin
                o_r  = w_sum;
                o_of = (i_a[63] == i_b[63]) && (w_sum[63] != i_a[63]);
            end
            AluSub: begin
                o_r  = w_diff;
                o_of = (i_a[63] != i_b[63]) && (w_diff[63] != i_b[63]);
            end
            AluAnd:  o_r = i_b & i_a;
            AluXor:  o_r = i_b ^ i_a;
            default: o_r = 64'h0;
        endcase
    end

    assign o_zf = (o_r == 64'h0);
    assign o_sf = o_r[63];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, operand selection, ALU, condition codes.
module execute_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  d_stat,
    input  logic [3:0]  d_icode,
    input  logic [3:0]  d_ifun,
    input  logic [63:0] d_valC,
    input  logic [63:0] d_valA,
    input  logic [63:0] d_valB,
    input  logic [3:0]  d_dstE,
    input  logic [3:0]  d_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        E_bubble,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic [2:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [2:0]  cc
);

    e_reg_t      r_e;
    logic [2:0]  r_cc;

    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [3:0]  w_alu_fun;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_set_cc;
    logic        w_cnd;

    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            r_e <= EBubble;
        end else begin
            r_e <= '{stat: d_stat, icode: d_icode, ifun: d_ifun, valc: d_valC, vala: d_valA,
                     valb: d_valB, dste: d_dstE, dstm: d_dstM, srca: d_srcA, srcb: d_srcB};
        end
    end

    // Flags come from the instruction already in E, so a bubble entering E does not block them.
    assign w_set_cc = (r_e.icode == IOpq) && !stat_blocks_cc(m_stat) && !stat_blocks_cc(W_stat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= CcReset;
        end else if (w_set_cc) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    always_comb begin
        w_alu_a = 64'h0;
        w_alu_b = 64'h0;
        case (r_e.icode)
            IRrmovq, IOpq:             w_alu_a = r_e.vala;
            IIrmovq, IRmmovq, IMrmovq: w_alu_a = r_e.valc;
            ICall, IPushq:             w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            IRet, IPopq:               w_alu_a = 64'h8;
            default:                   w_alu_a = 64'h0;
        endcase
        case (r_e.icode)
            IRmmovq, IMrmovq, IOpq, ICall, IPushq, IRet, IPopq: w_alu_b = r_e.valb;
            default:                                            w_alu_b = 64'h0;
        endcase
    end

    assign w_alu_fun = (r_e.icode == IOpq) ? r_e.ifun : AluAdd;

    y86_alu u_alu (
        .i_a   (w_alu_a),
        .i_b   (w_alu_b),
        .i_fun (w_alu_fun),
        .o_r   (e_valE),
        .o_zf  (w_zf),
        .o_sf  (w_sf),
        .o_of  (w_of)
    );

    assign w_cnd  = cond_eval(r_e.ifun, r_cc);
    assign e_Cnd  = w_cnd;
    assign e_dstE = ((r_e.icode == IRrmovq) && !w_cnd) ? RNONE : r_e.dste;
    assign cc     = r_cc;

    assign E_stat  = r_e.stat;
    assign E_icode = r_e.icode;
    assign E_ifun  = r_e.ifun;
    assign E_valC  = r_e.valc;
    assign E_valA  = r_e.vala;
    assign E_valB  = r_e.valb;
    assign E_dstM  = r_e.dstm;
    assign E_srcA  = r_e.srca;
    assign E_srcB  = r_e.srcb;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios plus random traffic vs a behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  d_stat;
    logic [3:0]  d_icode, d_ifun;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
    logic        E_bubble;
    logic [2:0]  m_stat, W_stat;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstM, E_srcA, E_srcB;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  cc;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk      (clk),
        .rst      (rst),
        .d_stat   (d_stat),
        .d_icode  (d_icode),
        .d_ifun   (d_ifun),
        .d_valC   (d_valC),
        .d_valA   (d_valA),
        .d_valB   (d_valB),
        .d_dstE   (d_dstE),
        .d_dstM   (d_dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_bubble (E_bubble),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .E_stat   (E_stat),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valC   (E_valC),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_dstM   (E_dstM),
        .E_srcA   (E_srcA),
        .E_srcB   (E_srcB),
        .e_valE   (e_valE),
        .e_dstE   (e_dstE),
        .e_Cnd    (e_Cnd),
        .cc       (cc)
    );

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } ins_t;

    typedef struct packed {
        logic [214:0] regs;
        logic [63:0]  vale;
        logic [3:0]   dste;
        logic         cnd;
        logic [2:0]   cc;
    } exp_t;

    exp_t       sb_q[$];
    ins_t       m_e;
    logic [2:0] m_cc;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic ins_t bubble_ins();
        ins_t b;
        b = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, valc: 64'h0, vala: 64'h0, valb: 64'h0,
              dste: 4'hF, dstm: 4'hF, srca: 4'hF, srcb: 4'hF};
        return b;
    endfunction

    function automatic ins_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] valc, input logic [63:0] vala,
                                input logic [63:0] valb, input logic [3:0] dste);
        ins_t i;
        i = '{stat: 3'd1, icode: icode, ifun: ifun, valc: valc, vala: vala, valb: valb,
              dste: dste, dstm: 4'h7, srca: 4'h5, srcb: 4'h6};
        return i;
    endfunction

    function automatic logic is_fault(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    // Reference: signed 65-bit arithmetic, overflow when the result leaves the 64-bit range.
    function automatic void model_exec(input ins_t e, input logic [2:0] c,
                                       output logic [63:0] val, output logic [2:0] flags,
                                       output logic cnd, output logic [3:0] dste);
        logic [63:0]        a, b;
        logic [3:0]         fn;
        logic signed [64:0] wide;
        logic               of, zf, sf, lt;
        case (e.icode)
            4'h2, 4'h6:       a = e.vala;
            4'h3, 4'h4, 4'h5: a = e.valc;
            4'h8, 4'hA:       a = -64'sd8;
            4'h9, 4'hB:       a = 64'd8;
            default:          a = 64'd0;
        endcase
        b  = (e.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? e.valb : 64'd0;
        fn = (e.icode == 4'h6) ? e.ifun : 4'h0;
        of = 1'b0;
        case (fn)
            4'h0: begin
                wide = $signed({b[63], b}) + $signed({a[63], a});
                val  = wide[63:0];
                of   = wide[64] != wide[63];
            end
            4'h1: begin
                wide = $signed({b[63], b}) - $signed({a[63], a});
                val  = wide[63:0];
                of   = wide[64] != wide[63];
            end
            4'h2:    val = a & b;
            4'h3:    val = a ^ b;
            default: val = 64'd0;
        endcase
        flags = {val == 64'd0, val[63], of};
        {zf, sf, lt} = {c[2], c[1], c[1] ^ c[0]};
        case (e.ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = lt || zf;
            4'h2:    cnd = lt;
            4'h3:    cnd = zf;
            4'h4:    cnd = !zf;
            4'h5:    cnd = !lt;
            4'h6:    cnd = !lt && !zf;
            default: cnd = 1'b0;
        endcase
        dste = (e.icode == 4'h2 && !cnd) ? 4'hF : e.dste;
    endfunction

    task automatic step(input ins_t d, input logic bub, input logic rs,
                        input logic [2:0] mst, input logic [2:0] wst);
        logic [63:0] v;
        logic [2:0]  fl;
        logic        c;
        logic [3:0]  de;
        exp_t        x;
        d_stat = d.stat;  d_icode = d.icode; d_ifun = d.ifun;
        d_valC = d.valc;  d_valA = d.vala;   d_valB = d.valb;
        d_dstE = d.dste;  d_dstM = d.dstm;   d_srcA = d.srca; d_srcB = d.srcb;
        E_bubble = bub;   rst = rs;          m_stat = mst;    W_stat = wst;
        model_exec(m_e, m_cc, v, fl, c, de);
        if (rs) begin
            m_e  = bubble_ins();
            m_cc = 3'b100;
        end else begin
            if (m_e.icode == 4'h6 && !is_fault(mst) && !is_fault(wst)) m_cc = fl;
            m_e = bub ? bubble_ins() : d;
        end
        model_exec(m_e, m_cc, v, fl, c, de);
        x.regs = {m_e.stat, m_e.icode, m_e.ifun, m_e.valc, m_e.vala, m_e.valb,
                  m_e.dstm, m_e.srca, m_e.srcb};
        x.vale = v;
        x.dste = de;
        x.cnd  = c;
        x.cc   = m_cc;
        @(posedge clk);
        sb_q.push_back(x);
        #2;
    endtask

    task automatic op(input ins_t d);
        step(d, 1'b0, 1'b0, 3'd1, 3'd1);
    endtask

    task automatic check_const(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: one result per clock after each issued step.
    initial begin
        exp_t         x;
        logic [214:0] act_regs;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                act_regs = {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
                            E_dstM, E_srcA, E_srcB};
                n_tests += 4;
                if (act_regs !== x.regs) begin
                    n_fail++;
                    $display("FAIL E_reg: got %0h, expected %0h", act_regs, x.regs);
                end
                if (e_valE !== x.vale) begin
                    n_fail++;
                    $display("FAIL e_valE: got %0h, expected %0h", e_valE, x.vale);
                end
                if (e_dstE !== x.dste || e_Cnd !== x.cnd) begin
                    n_fail++;
                    $display("FAIL dstE_cnd: got %0h/%0b, expected %0h/%0b",
                             e_dstE, e_Cnd, x.dste, x.cnd);
                end
                if (cc !== x.cc) begin
                    n_fail++;
                    $display("FAIL cc: got %03b, expected %03b", cc, x.cc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ins_t d;
        m_e  = bubble_ins();
        m_cc = 3'b100;
        rst  = 1'b1;
        E_bubble = 1'b0;
        m_stat = 3'd1;
        W_stat = 3'd1;
        @(posedge clk);
        #2;

        step(mk(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2), 1'b0, 1'b1, 3'd1, 3'd1);
        check_const("rst_icode", 64'(E_icode), 64'h1);
        check_const("rst_cc", 64'(cc), 64'h4);
        check_const("rst_dstM", 64'(E_dstM), 64'hF);

        // Sub to zero, then equal-condition jump sees ZF.
        op(mk(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2));
        op(mk(4'h6, 4'h1, 64'h0, 64'h5, 64'h5, 4'h2));
        check_const("sub_valE", e_valE, 64'h0);
        check_const("sub_cc_before", 64'(cc), 64'h0);
        op(mk(4'h7, 4'h3, 64'h40, 64'h0, 64'h0, 4'hF));
        check_const("sub_cc_after", 64'(cc), 64'h4);
        check_const("je_cnd", 64'(e_Cnd), 64'h1);

        // Positive overflow on add.
        op(mk(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h2));
        check_const("ovf_valE", e_valE, 64'h8000_0000_0000_0000);
        op(mk(4'h7, 4'h1, 64'h40, 64'h0, 64'h0, 4'hF));
        check_const("ovf_cc", 64'(cc), 64'h3);
        check_const("ovf_le", 64'(e_Cnd), 64'h0);
        op(mk(4'h7, 4'h6, 64'h40, 64'h0, 64'h0, 4'hF));
        check_const("ovf_g", 64'(e_Cnd), 64'h1);

        // Conditional move (ne) with ZF clear, then with ZF set.
        op(mk(4'h2, 4'h4, 64'h0, 64'h1234, 64'h0, 4'h3));
        check_const("cmovne_taken_dstE", 64'(e_dstE), 64'h3);
        check_const("cmovne_taken_valE", e_valE, 64'h1234);
        op(mk(4'h6, 4'h3, 64'h0, 64'h9, 64'h9, 4'h2));
        op(mk(4'h2, 4'h4, 64'h0, 64'h1234, 64'h0, 4'h3));
        check_const("cmovne_nt_dstE", 64'(e_dstE), 64'hF);

        // Stack pointer adjust; no flag update.
        op(mk(4'hA, 4'h0, 64'h0, 64'h55, 64'h100, 4'h4));
        check_const("push_valE", e_valE, 64'hF8);
        op(mk(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4));
        check_const("pop_valE", e_valE, 64'h108);
        op(bubble_ins());
        check_const("pop_cc", 64'(cc), 64'h4);

        // Downstream exception blocks CC; bubble lands in E.
        op(mk(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2));
        step(mk(4'h3, 4'h0, 64'h9, 64'h0, 64'h0, 4'h1), 1'b1, 1'b0, 3'd3, 3'd1);
        check_const("adr_cc_held", 64'(cc), 64'h4);
        check_const("bub_icode", 64'(E_icode), 64'h1);
        check_const("bub_dstM", 64'(E_dstM), 64'hF);

        // Bubble does not suppress the flags of the OPQ already in E.
        op(mk(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2));
        step(mk(4'h3, 4'h0, 64'h9, 64'h0, 64'h0, 4'h1), 1'b1, 1'b0, 3'd1, 3'd1);
        check_const("bub_cc_update", 64'(cc), 64'h0);

        // Reset mid-stream discards E and the pending flag update.
        op(mk(4'h6, 4'h1, 64'h0, 64'h1, 64'h1, 4'h2));
        op(mk(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2));
        step(mk(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2), 1'b0, 1'b1, 3'd1, 3'd1);
        check_const("mrst_cc", 64'(cc), 64'h4);
        check_const("mrst_stat", 64'(E_stat), 64'h1);
        check_const("mrst_icode", 64'(E_icode), 64'h1);
        check_const("mrst_dstE", 64'(e_dstE), 64'hF);

        for (int i = 0; i < 400; i++) begin
            d.stat  = 3'($urandom_range(0, 7));
            d.icode = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            d.ifun  = 4'($urandom_range(0, 8));
            d.valc  = rnd64();
            d.vala  = rnd64();
            d.valb  = rnd64();
            d.dste  = 4'($urandom);
            d.dstm  = 4'($urandom);
            d.srca  = 4'($urandom);
            d.srcb  = 4'($urandom);
            step(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1,
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1);
        end

        repeat (3) @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
